rng_sample_buf: RTL and testbench
=================================

RNG_SAMPLE_BUF -- requirements
Module: rng_sample_buf

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the random word width.
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the buffer depth in words (power of two, >=2).
REQ-003 The module SHALL have parameter DIV_WIDTH, default 8, meaning the sample-divider width.
REQ-004 clk_i  input  1  clock; single clock domain, all logic rising-edge.
REQ-005 rst_i  input  1  reset; asynchronous and active-high.
REQ-006 en_i  input  1  sampling enable.
REQ-007 div_i  input  DIV_WIDTH  sample interval minus one (sample every div_i+1 cycles).
REQ-008 dat_i  input  DATA_WIDTH  generator output word, sampled on the sample strobe.
REQ-009 flush_i  input  1  synchronous buffer clear.
REQ-010 rd_i  input  1  pop request from the register interface.
REQ-011 dat_o  output  DATA_WIDTH  head word, first-word-fall-through; 0 when empty.
REQ-012 valid_o  output  1  buffer not empty.
REQ-013 full_o  output  1  buffer holds DEPTH words.
REQ-014 cnt_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 ovf_o  output  1  sticky overflow: a sample was dropped.
REQ-016 udf_o  output  1  sticky underflow: rd_i arrived while empty.

Function
REQ-017 Divider counter SHALL hold at 0 while en_i=0, and increment each cycle while en_i=1.
REQ-018 Sample strobe SHALL assert for one cycle when en_i=1 and counter>=div_i, and the counter SHALL return to 0 in that cycle (the >= comparison covers div_i being lowered mid-count).
REQ-019 div_i=0 with en_i=1 SHALL strobe every cycle.
REQ-020 On a strobe with the buffer not full, dat_i SHALL be written at the tail; the word SHALL appear on dat_o/valid_o the following cycle if the buffer was empty (latency 1).
REQ-021 On a strobe with the buffer full and no pop in that cycle, the sample SHALL be dropped, contents SHALL be unchanged, and ovf_o SHALL be set.
REQ-022 On a strobe with the buffer full and rd_i=1 in the same cycle, both the pop and the push SHALL occur, cnt_o SHALL stay DEPTH, and ovf_o SHALL not be set.
REQ-023 rd_i=1 with valid_o=1 SHALL advance the head; the next word, or 0 if now empty, SHALL appear the following cycle.
REQ-024 rd_i=1 with valid_o=0 SHALL not change pointers and SHALL set udf_o.
REQ-025 A simultaneous push and pop on an empty buffer SHALL perform only the push (cnt_o 0->1), and SHALL set udf_o.
REQ-026 Read and write pointers SHALL wrap from DEPTH-1 to 0; cnt_o SHALL never exceed DEPTH.
REQ-027 flush_i SHALL have priority over push and pop: pointers, cnt_o, ovf_o, udf_o and the divider counter SHALL clear next cycle.
REQ-028 The sample in a flush cycle SHALL be discarded.

Reset
REQ-029 rst_i=1 SHALL asynchronously clear pointers, divider counter, cnt_o, ovf_o and udf_o, giving dat_o=0, valid_o=0 and full_o=0.
REQ-030 Storage array contents SHALL not require reset.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words.
REQ-032 After reset deassertion, the first strobe SHALL occur div_i+1 cycles after en_i is seen high.

Structure
REQ-033 A shared package rng_pkg SHALL hold the DATA_WIDTH default, the polynomial constant 32'h04C1_1DB7, and the register offset constants CTRL 0x0, SEED 0x4, VAL 0x8, STAT 0xC.
REQ-034 One sub-module rng_fifo (pointer, count and storage logic) SHALL be instantiated; the divider and sticky flags SHALL live in the top module.

Verification
REQ-035 Reset, then en_i=1, div_i=3, dat_i=32'hA5A5_0001 held: first valid_o 5 cycles after en_i, dat_o=32'hA5A5_0001, cnt_o increments every 4 cycles.
REQ-036 Fill with div_i=0 and no reads: full_o after 8 strobes, 9th strobe sets ovf_o, cnt_o=8, and dat_o still equals the first word.
REQ-037 Full buffer, strobe and rd_i in the same cycle: cnt_o stays 8, ovf_o=0, and the head advances to the second word.
REQ-038 rd_i on empty: udf_o=1, cnt_o=0; then flush_i=1 for one cycle clears udf_o and ovf_o.
REQ-039 Write 8 words, read 8, repeat 3 times: read sequence equals write order across pointer wrap.
REQ-040 Assert rst_i mid-fill at cnt_o=5: outputs clear the same cycle without waiting for a clock edge, valid_o=0.

Source files
------------

// File: rtl/rng_pkg.sv
// rng_pkg: shared constants for the RNG block and its register map
package rng_pkg;

    localparam int          RNG_DATA_WIDTH = 32;
    localparam logic [31:0] RNG_POLY       = 32'h04C1_1DB7;

    typedef enum logic [3:0] {
        REG_CTRL = 4'h0,
        REG_SEED = 4'h4,
        REG_VAL  = 4'h8,
        REG_STAT = 4'hC
    } reg_off_e;

endpackage

// File: rtl/rng_fifo.sv
// rng_fifo: first-word-fall-through sample buffer with occupancy count
module rng_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [$clog2(DEPTH):0]  cnt,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rptr;
    logic [AW-1:0]         wptr;
    logic                  do_pop;
    logic                  do_push;

    assign empty   = cnt == '0;
    assign full    = cnt == CW'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rptr];

    // pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage needs no reset; stale words are never visible past the pointers
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/rng_sample_buf.sv
// rng_sample_buf: samples the generator word at a programmable interval into a FWFT buffer
module rng_sample_buf
    import rng_pkg::*;
#(
    parameter int DATA_WIDTH = RNG_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [DIV_WIDTH-1:0]    div_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic                    flush_i,
    input  logic                    rd_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    valid_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  cnt_o,
    output logic                    ovf_o,
    output logic                    udf_o
);

    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 strobe;
    logic                 full;
    logic                 empty;

    // divider: registered strobe once the count reaches div_i (>= tolerates div_i dropping mid-count)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            strobe  <= 1'b0;
        end else if (flush_i || !en_i) begin
            div_cnt <= '0;
            strobe  <= 1'b0;
        end else if (div_cnt >= div_i) begin
            div_cnt <= '0;
            strobe  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
            strobe  <= 1'b0;
        end
    end

    // sticky flags: a dropped sample needs a full buffer with no same-cycle pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else if (flush_i) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (strobe && full && !rd_i) ovf_o <= 1'b1;
            if (rd_i && empty)           udf_o <= 1'b1;
        end
    end

    rng_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (flush_i),
        .push  (strobe),
        .pop   (rd_i),
        .wdata (dat_i),
        .rdata (dat_o),
        .cnt   (cnt_o),
        .full  (full),
        .empty (empty)
    );

    assign valid_o = ~empty;
    assign full_o  = full;

endmodule

// File: tb/tb_rng_sample_buf.sv
// tb_rng_sample_buf: directed scenario checks for the sampled RNG buffer
module tb_rng_sample_buf;

    localparam int DW  = 32;
    localparam int DEP = 8;
    localparam int DVW = 8;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           flush = 1'b0;
    logic           rd = 1'b0;
    logic [DVW-1:0] div = '0;
    logic [DW-1:0]  dat = '0;
    logic [DW-1:0]  dat_o;
    logic           valid_o;
    logic           full_o;
    logic [CW-1:0]  cnt_o;
    logic           ovf_o;
    logic           udf_o;
    int             checks = 0;
    int             failures = 0;

    always #5 clk = ~clk;

    rng_sample_buf #(.DATA_WIDTH(DW), .DEPTH(DEP), .DIV_WIDTH(DVW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .div_i   (div),
        .dat_i   (dat),
        .flush_i (flush),
        .rd_i    (rd),
        .dat_o   (dat_o),
        .valid_o (valid_o),
        .full_o  (full_o),
        .cnt_o   (cnt_o),
        .ovf_o   (ovf_o),
        .udf_o   (udf_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; rd = 1'b0; div = '0; dat = '0;
        tick();
        rst = 1'b0;
    endtask

    // n back-to-back samples base, base+1, ... with div=0; the sampler is idle afterwards
    task automatic strobe_words(input int n, input logic [DW-1:0] base);
        div = '0;
        en = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            dat = base + DW'(i);
            if (i == n - 1) en = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dat_o !== '0) begin failures++; $display("FAIL reset_dat got=%h exp=0", dat_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full_o); end
        checks++; if (cnt_o !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
        checks++; if (ovf_o !== 1'b0 || udf_o !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", ovf_o, udf_o); end
    endtask

    task automatic test_first_sample();
        do_reset();
        div = 8'd3; dat = 32'hA5A5_0001; en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 4) begin
                checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL first_early_valid got=%b exp=0", valid_o); end
            end
            if (k == 5) begin
                checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", valid_o); end
                checks++; if (dat_o !== 32'hA5A5_0001) begin failures++; $display("FAIL first_dat got=%h exp=a5a50001", dat_o); end
            end
            if (k == 8) begin
                checks++; if (cnt_o !== 4'd1) begin failures++; $display("FAIL first_cnt8 got=%0d exp=1", cnt_o); end
            end
            if (k == 9) begin
                checks++; if (cnt_o !== 4'd2) begin failures++; $display("FAIL first_cnt9 got=%0d exp=2", cnt_o); end
            end
            if (k == 13) begin
                checks++; if (cnt_o !== 4'd3) begin failures++; $display("FAIL first_cnt13 got=%0d exp=3", cnt_o); end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_div_lower();
        do_reset();
        div = 8'd5; dat = 32'h0000_0700; en = 1'b1;
        tick(); tick(); tick();
        div = 8'd1;
        tick();
        checks++; if (cnt_o !== 4'd0) begin failures++; $display("FAIL divlow_cnt0 got=%0d exp=0", cnt_o); end
        tick();
        en = 1'b0;
        checks++; if (cnt_o !== 4'd1 || dat_o !== 32'h0000_0700) begin failures++; $display("FAIL divlow_push got=%0d/%h exp=1/00000700", cnt_o, dat_o); end
    endtask

    task automatic test_fill_ovf();
        do_reset();
        strobe_words(7, 32'h100);
        checks++; if (full_o !== 1'b0 || cnt_o !== 4'd7) begin failures++; $display("FAIL fill7 got=%b/%0d exp=0/7", full_o, cnt_o); end
        strobe_words(1, 32'h107);
        checks++; if (full_o !== 1'b1 || cnt_o !== 4'd8) begin failures++; $display("FAIL fill8 got=%b/%0d exp=1/8", full_o, cnt_o); end
        checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL fill8_ovf got=%b exp=0", ovf_o); end
        strobe_words(1, 32'h108);
        checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL fill9_ovf got=%b exp=1", ovf_o); end
        checks++; if (cnt_o !== 4'd8 || dat_o !== 32'h100) begin failures++; $display("FAIL fill9_keep got=%0d/%h exp=8/00000100", cnt_o, dat_o); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        strobe_words(8, 32'h200);
        div = '0; en = 1'b1;
        tick();
        en = 1'b0; dat = 32'h208; rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++; if (cnt_o !== 4'd8 || full_o !== 1'b1) begin failures++; $display("FAIL fpp_cnt got=%0d/%b exp=8/1", cnt_o, full_o); end
        checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%b exp=0", ovf_o); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (dat_o !== 32'h200 + DW'(i)) begin failures++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, dat_o, 32'h200 + DW'(i)); end
            rd = 1'b1; tick(); rd = 1'b0;
        end
        checks++; if (valid_o !== 1'b0 || dat_o !== '0) begin failures++; $display("FAIL fpp_empty got=%b/%h exp=0/0", valid_o, dat_o); end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        div = '0; en = 1'b1;
        tick();
        en = 1'b0; dat = 32'h400; rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++; if (cnt_o !== 4'd1 || dat_o !== 32'h400) begin failures++; $display("FAIL epp_push got=%0d/%h exp=1/00000400", cnt_o, dat_o); end
        checks++; if (udf_o !== 1'b1) begin failures++; $display("FAIL epp_udf got=%b exp=1", udf_o); end
    endtask

    task automatic test_underflow_flush();
        do_reset();
        strobe_words(9, 32'h300);
        rd = 1'b1;
        repeat (8) tick();
        rd = 1'b0;
        checks++; if (udf_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL uf_drain got=%b/%b exp=0/0", udf_o, valid_o); end
        rd = 1'b1; tick(); rd = 1'b0;
        checks++; if (udf_o !== 1'b1 || cnt_o !== 4'd0) begin failures++; $display("FAIL uf_udf got=%b/%0d exp=1/0", udf_o, cnt_o); end
        checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL uf_ovf_held got=%b exp=1", ovf_o); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (udf_o !== 1'b0 || ovf_o !== 1'b0) begin failures++; $display("FAIL flush_flags got=%b%b exp=00", udf_o, ovf_o); end
        strobe_words(3, 32'h310);
        checks++; if (cnt_o !== 4'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", cnt_o); end
        div = '0; en = 1'b1;
        tick();
        en = 1'b0; flush = 1'b1; dat = 32'h3FF;
        tick();
        flush = 1'b0;
        tick();
        checks++; if (cnt_o !== 4'd0 || valid_o !== 1'b0 || dat_o !== '0) begin failures++; $display("FAIL flush_discard got=%0d/%b/%h exp=0/0/0", cnt_o, valid_o, dat_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            strobe_words(8, 32'h500 + DW'(r * 16));
            checks++; if (full_o !== 1'b1) begin failures++; $display("FAIL wrap_full%0d got=%b exp=1", r, full_o); end
            for (int i = 0; i < 8; i++) begin
                checks++; if (dat_o !== 32'h500 + DW'(r * 16 + i)) begin failures++; $display("FAIL wrap_r%0d_w%0d got=%h exp=%h", r, i, dat_o, 32'h500 + DW'(r * 16 + i)); end
                rd = 1'b1; tick(); rd = 1'b0;
            end
        end
        checks++; if (valid_o !== 1'b0 || udf_o !== 1'b0) begin failures++; $display("FAIL wrap_end got=%b/%b exp=0/0", valid_o, udf_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        strobe_words(5, 32'h600);
        checks++; if (cnt_o !== 4'd5) begin failures++; $display("FAIL arst_pre got=%0d exp=5", cnt_o); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (cnt_o !== 4'd0 || valid_o !== 1'b0) begin failures++; $display("FAIL arst_now got=%0d/%b exp=0/0", cnt_o, valid_o); end
        checks++; if (dat_o !== '0 || full_o !== 1'b0) begin failures++; $display("FAIL arst_dat got=%h/%b exp=0/0", dat_o, full_o); end
        tick();
        rst = 1'b0;
        tick(); tick();
        checks++; if (valid_o !== 1'b0 || cnt_o !== 4'd0) begin failures++; $display("FAIL arst_after got=%b/%0d exp=0/0", valid_o, cnt_o); end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_div_lower();
        test_fill_ovf();
        test_full_push_pop();
        test_empty_push_pop();
        test_underflow_flush();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
